// File: rtl/sa_pipe_skid.sv
// Registered valid/ready pipe stage with a 2-entry skid buffer; all outputs come straight from flops.
// Optional stall counter ports/logic are built only when SA_PIPE_SKID_STALL_CNT_EN is defined.
module sa_pipe_skid #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             autosa_core_clk,
    input  logic             autosa_core_rstn,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [DW-1:0]    in_pd,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [DW-1:0]    out_pd
`ifdef SA_PIPE_SKID_STALL_CNT_EN
    ,
    input  logic             stall_clr,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    // State encoding doubles as {out_vld, skid_vld}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b10,
        ST_FULL  = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   out_pd_q, out_pd_d;
    logic [DW-1:0]   skid_pd_q, skid_pd_d;
    logic            in_rdy_q, in_rdy_d;
    logic            push_s, pop_s;

    assign push_s  = in_vld & in_rdy_q;
    assign pop_s   = state_q[1] & out_rdy;
    assign out_vld = state_q[1];
    assign out_pd  = out_pd_q;
    assign in_rdy  = in_rdy_q;

    // Next-state and payload routing for the two-entry stage.
    always_comb begin
        state_d   = state_q;
        out_pd_d  = out_pd_q;
        skid_pd_d = skid_pd_q;
        case (state_q)
            ST_EMPTY: begin
                if (push_s) begin
                    out_pd_d = in_pd;
                    state_d  = ST_BUSY;
                end else begin
                    state_d  = ST_EMPTY;
                end
            end
            ST_BUSY: begin
                if (push_s && pop_s) begin
                    out_pd_d  = in_pd;
                    state_d   = ST_BUSY;
                end else if (push_s) begin
                    skid_pd_d = in_pd;
                    state_d   = ST_FULL;
                end else if (pop_s) begin
                    state_d   = ST_EMPTY;
                end else begin
                    state_d   = ST_BUSY;
                end
            end
            ST_FULL: begin
                if (pop_s) begin
                    out_pd_d = skid_pd_q;
                    state_d  = ST_BUSY;
                end else begin
                    state_d  = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        in_rdy_d = ~state_d[0];
    end

    // Stage registers with synchronous active-low reset.
    always_ff @(posedge autosa_core_clk) begin
        if (!autosa_core_rstn) begin
            state_q   <= ST_EMPTY;
            out_pd_q  <= {DW{1'b0}};
            skid_pd_q <= {DW{1'b0}};
            in_rdy_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            out_pd_q  <= out_pd_d;
            skid_pd_q <= skid_pd_d;
            in_rdy_q  <= in_rdy_d;
        end
    end

`ifdef SA_PIPE_SKID_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    assign stall_cnt = stall_q;

    // Saturating stall count; clear wins over a same-cycle increment.
    always_comb begin
        stall_d = stall_q;
        if (stall_clr) begin
            stall_d = {CNT_W{1'b0}};
        end else if (state_q[1] && !out_rdy && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge autosa_core_clk) begin
        if (!autosa_core_rstn) begin
            stall_q <= {CNT_W{1'b0}};
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_sa_pipe_skid.sv
// Scoreboard bench for sa_pipe_skid: reset, streaming, backpressure, random traffic, mid-op reset,
// and the stall counter when SA_PIPE_SKID_STALL_CNT_EN is defined.
module tb_sa_pipe_skid;

    localparam int DW    = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rstn;
    logic             in_vld;
    logic             in_rdy;
    logic [DW-1:0]    in_pd;
    logic             out_vld;
    logic             out_rdy;
    logic [DW-1:0]    out_pd;
    logic             stall_clr;
    logic [CNT_W-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_pd    = '0;

    sa_pipe_skid #(.DW(DW), .CNT_W(CNT_W)) dut (
        .autosa_core_clk  (clk),
        .autosa_core_rstn (rstn),
        .in_vld           (in_vld),
        .in_rdy           (in_rdy),
        .in_pd            (in_pd),
        .out_vld          (out_vld),
        .out_rdy          (out_rdy),
        .out_pd           (out_pd)
`ifdef SA_PIPE_SKID_STALL_CNT_EN
        ,
        .stall_clr        (stall_clr),
        .stall_cnt        (stall_cnt)
`endif
    );

`ifndef SA_PIPE_SKID_STALL_CNT_EN
    assign stall_cnt = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Negedge monitor: scoreboard pop/push plus output stability under stall.
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_vld", {31'd0, out_vld}, 32'd1);
                check_eq("hold_pd", out_pd, prev_pd);
            end
            if (out_vld) begin
                check_eq("pd_known", {31'd0, $isunknown(out_pd)}, 32'd0);
            end
            if (out_vld && out_rdy) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", exp_q.size(), 32'd1);
                end else begin
                    check_eq("sb_data", out_pd, exp_q.pop_front());
                end
            end
            if (in_vld && in_rdy) begin
                exp_q.push_back(in_pd);
            end
            prev_stall <= out_vld && !out_rdy;
            prev_pd    <= out_pd;
        end
    end

    initial begin
        int pushed;
        rstn      = 1'b0;
        in_vld    = 1'b1;
        in_pd     = 32'hDEAD_BEEF;
        out_rdy   = 1'b1;
        stall_clr = 1'b0;

        // 1: reset held 3 cycles with in_vld high
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_out_vld", {31'd0, out_vld}, 32'd0);
            check_eq("rst_out_pd", out_pd, 32'd0);
            check_eq("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
        end
        check_eq("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        rstn   = 1'b1;
        in_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("post_rst_vld", {31'd0, out_vld}, 32'd0);
        end

        // 2: streaming with 1-cycle latency
        out_rdy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_vld = 1'b1;
            in_pd  = 32'(i);
            tick();
            check_eq("strm_vld", {31'd0, out_vld}, 32'd1);
            check_eq("strm_pd", out_pd, 32'(i));
            check_eq("strm_rdy", {31'd0, in_rdy}, 32'd1);
        end
        in_vld = 1'b0;
        tick();
        check_eq("strm_empty", {31'd0, out_vld}, 32'd0);

        // 3: backpressure absorbs two, holds the third upstream
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        in_pd   = 32'hA;
        tick();
        check_eq("bp_rdy_a", {31'd0, in_rdy}, 32'd1);
        check_eq("bp_pd_a", out_pd, 32'hA);
        in_pd = 32'hB;
        tick();
        check_eq("bp_rdy_b", {31'd0, in_rdy}, 32'd0);
        in_pd = 32'hC;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("bp_full_rdy", {31'd0, in_rdy}, 32'd0);
            check_eq("bp_full_pd", out_pd, 32'hA);
        end
        out_rdy = 1'b1;
        tick();
        check_eq("bp_rel_b", out_pd, 32'hB);
        check_eq("bp_rel_rdy", {31'd0, in_rdy}, 32'd1);
        tick();
        check_eq("bp_rel_c", out_pd, 32'hC);
        in_vld = 1'b0;
        tick();
        check_eq("bp_drained", {31'd0, out_vld}, 32'd0);

        // 4: random traffic, in_pd is X whenever in_vld is low
        pushed = 0;
        for (int cyc = 0; cyc < 60000 && pushed < 10000; cyc++) begin
            in_vld  = ($urandom_range(0, 3) != 0);
            in_pd   = in_vld ? $urandom() : 'x;
            out_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_vld && in_rdy) pushed++;
            @(posedge clk);
            #1;
        end
        check_eq("rand_pushed", pushed, 32'd10000);
        in_vld  = 1'b0;
        in_pd   = '0;
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_eq("rand_drain", exp_q.size(), 32'd0);

        // 5: reset while FULL discards both entries
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        in_pd   = 32'h55;
        tick();
        in_pd = 32'h66;
        tick();
        in_vld = 1'b0;
        check_eq("mid_full_rdy", {31'd0, in_rdy}, 32'd0);
        check_eq("mid_full_vld", {31'd0, out_vld}, 32'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check_eq("mid_rst_vld", {31'd0, out_vld}, 32'd0);
        check_eq("mid_rst_rdy", {31'd0, in_rdy}, 32'd1);
        check_eq("mid_rst_pd", out_pd, 32'd0);
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("mid_no_out", {31'd0, out_vld}, 32'd0);
        end

`ifdef SA_PIPE_SKID_STALL_CNT_EN
        // 6: stall counter saturation and clear
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        out_rdy   = 1'b0;
        in_vld    = 1'b1;
        in_pd     = 32'h77;
        tick();
        in_vld = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check_eq("stall_sat", {28'd0, stall_cnt}, 32'd15);
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        check_eq("stall_clr", {28'd0, stall_cnt}, 32'd0);
        tick();
        check_eq("stall_recount", {28'd0, stall_cnt}, 32'd1);
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) tick();
`endif

        check_eq("final_drain", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
